// File: rtl/fx_chain_scheduler.sv
// ----------------------------------------------------------------------------
// fx_chain_scheduler
//
// Runs the audio-effect chain once for each incoming sample. Enabled slots are
// visited in index order. Each one gets a single-cycle turn pulse, and the
// scheduler then waits for that slot's done. The running sample lives in one
// register. Each finishing slot overwrites it, and a bypassed slot leaves it
// bit-exact. The single smart_ram read port is granted only to the slot that
// is currently waiting.
//
// Optional feature: define FX_WATCHDOG_EN to add a per-effect watchdog. If a
// slot does not finish within TIMEOUT cycles, it is skipped and its sticky
// fx_timeout flag is set.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   sample_valid/in   new sample strobe and data from the codec side
//   fx_enable         per-slot enable, captured with each sample
//   fx_turn           one-hot my_turn pulse to the slot being started
//   fx_data_in        running sample presented to every slot
//   fx_done/data_out  per-slot completion and result (slot k at k*DATA_WIDTH)
//   fx_rd/offset      per-slot smart_ram read request and offset
//   fx_read_finish    read completion routed to the granted slot
//   sram_rd/offset    smart_ram read port, sram_read_finish its completion
//   sample_out(_valid) processed sample and its one-cycle strobe
//   busy, overrun     processing status, dropped-sample pulse
//   fx_timeout        sticky per-slot watchdog flags (0 without the watchdog)
// ----------------------------------------------------------------------------
module fx_chain_scheduler #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 13,
    parameter int NUM_FX     = 4,
    parameter int TIMEOUT    = 1023
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         sample_valid,
    input  logic signed [DATA_WIDTH-1:0] sample_in,
    input  logic [NUM_FX-1:0]            fx_enable,
    output logic [NUM_FX-1:0]            fx_turn,
    output logic signed [DATA_WIDTH-1:0] fx_data_in,
    input  logic [NUM_FX-1:0]            fx_done,
    input  logic [NUM_FX*DATA_WIDTH-1:0] fx_data_out,
    input  logic [NUM_FX-1:0]            fx_rd,
    input  logic [NUM_FX*ADDR_WIDTH-1:0] fx_offset,
    output logic [NUM_FX-1:0]            fx_read_finish,
    output logic                         sram_rd,
    output logic [ADDR_WIDTH-1:0]        sram_offset,
    input  logic                         sram_read_finish,
    output logic signed [DATA_WIDTH-1:0] sample_out,
    output logic                         sample_out_valid,
    output logic                         busy,
    output logic                         overrun,
    output logic [NUM_FX-1:0]            fx_timeout
);

    typedef enum logic [2:0] {S_IDLE, S_SELECT, S_TURN, S_WAIT, S_OUT} state_t;

    state_t                         state_q, state_d;
    logic [3:0]                     idx_q, idx_d;
    logic [NUM_FX-1:0]              en_q, en_d;
    logic signed [DATA_WIDTH-1:0]   run_q, run_d;
    logic signed [DATA_WIDTH-1:0]   sample_out_q, sample_out_d;
    logic                           sample_out_valid_q, sample_out_valid_d;
    logic                           busy_q, busy_d;
    logic                           overrun_q, overrun_d;
    logic [NUM_FX-1:0]              fx_turn_q, fx_turn_d;
    logic [ADDR_WIDTH-1:0]          off_hold_q, off_hold_d;
`ifdef FX_WATCHDOG_EN
    logic [10:0]                    wd_cnt_q, wd_cnt_d;
    logic [NUM_FX-1:0]              fx_timeout_q, fx_timeout_d;
`endif

    // Slot currently addressed by idx_q: its result, request and done.
    logic signed [DATA_WIDTH-1:0]   slot_data;
    logic [ADDR_WIDTH-1:0]          slot_off;
    logic                           slot_rd;
    logic                           slot_done;
    logic [NUM_FX-1:0]              idx_onehot;

    always_comb begin
        slot_data  = '0;
        slot_off   = '0;
        slot_rd    = 1'b0;
        slot_done  = 1'b0;
        idx_onehot = '0;
        for (int k = 0; k < NUM_FX; k++) begin
            if (idx_q == 4'(k)) begin
                slot_data     = fx_data_out[k*DATA_WIDTH +: DATA_WIDTH];
                slot_off      = fx_offset[k*ADDR_WIDTH +: ADDR_WIDTH];
                slot_rd       = fx_rd[k];
                slot_done     = fx_done[k];
                idx_onehot[k] = 1'b1;
            end
        end
    end

    // Lowest enabled slot at or above idx_q.
    logic              found;
    logic [3:0]        pick;
    logic [NUM_FX-1:0] pick_onehot;

    always_comb begin
        found       = 1'b0;
        pick        = '0;
        pick_onehot = '0;
        for (int k = 0; k < NUM_FX; k++) begin
            if (!found && en_q[k] && (4'(k) >= idx_q)) begin
                found          = 1'b1;
                pick           = 4'(k);
                pick_onehot[k] = 1'b1;
            end
        end
    end

    // Read port grant: only the waiting slot reaches smart_ram, and the
    // offset holds its last granted value otherwise.
    always_comb begin
        sram_rd        = (state_q == S_WAIT) && slot_rd;
        sram_offset    = (state_q == S_WAIT) ? slot_off : off_hold_q;
        fx_read_finish = (state_q == S_WAIT) ? (idx_onehot & {NUM_FX{sram_read_finish}}) : '0;
        off_hold_d     = sram_offset;
    end

    always_comb begin
        state_d            = state_q;
        idx_d              = idx_q;
        en_d               = en_q;
        run_d              = run_q;
        sample_out_d       = sample_out_q;
        sample_out_valid_d = 1'b0;
        fx_turn_d          = '0;
        // Any strobe outside IDLE (OUT included) is dropped and flagged.
        overrun_d          = sample_valid && (state_q != S_IDLE);
`ifdef FX_WATCHDOG_EN
        wd_cnt_d           = wd_cnt_q;
        fx_timeout_d       = fx_timeout_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (sample_valid) begin
                    run_d   = sample_in;
                    en_d    = fx_enable;
                    idx_d   = '0;
                    state_d = S_SELECT;
                end
            end
            S_SELECT: begin
                if (found) begin
                    idx_d     = pick;
                    fx_turn_d = pick_onehot;
                    state_d   = S_TURN;
                end else begin
                    state_d = S_OUT;
                end
            end
            S_TURN: begin
`ifdef FX_WATCHDOG_EN
                wd_cnt_d = '0;
`endif
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (slot_done) begin
                    run_d   = slot_data;
                    idx_d   = idx_q + 4'd1;
                    state_d = S_SELECT;
                end
`ifdef FX_WATCHDOG_EN
                // wd_cnt_q counts completed WAIT cycles, so this is the
                // TIMEOUT-th one: give up and bypass the slot.
                else if (wd_cnt_q == 11'(TIMEOUT - 1)) begin
                    fx_timeout_d = fx_timeout_q | idx_onehot;
                    idx_d        = idx_q + 4'd1;
                    state_d      = S_SELECT;
                end else begin
                    wd_cnt_d = wd_cnt_q + 11'd1;
                end
`endif
            end
            S_OUT: begin
                sample_out_d       = run_q;
                sample_out_valid_d = 1'b1;
                state_d            = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q            <= S_IDLE;
            idx_q              <= '0;
            en_q               <= '0;
            run_q              <= '0;
            sample_out_q       <= '0;
            sample_out_valid_q <= 1'b0;
            busy_q             <= 1'b0;
            overrun_q          <= 1'b0;
            fx_turn_q          <= '0;
            off_hold_q         <= '0;
`ifdef FX_WATCHDOG_EN
            wd_cnt_q           <= '0;
            fx_timeout_q       <= '0;
`endif
        end else begin
            state_q            <= state_d;
            idx_q              <= idx_d;
            en_q               <= en_d;
            run_q              <= run_d;
            sample_out_q       <= sample_out_d;
            sample_out_valid_q <= sample_out_valid_d;
            busy_q             <= busy_d;
            overrun_q          <= overrun_d;
            fx_turn_q          <= fx_turn_d;
            off_hold_q         <= off_hold_d;
`ifdef FX_WATCHDOG_EN
            wd_cnt_q           <= wd_cnt_d;
            fx_timeout_q       <= fx_timeout_d;
`endif
        end
    end

    assign fx_turn          = fx_turn_q;
    assign fx_data_in       = run_q;
    assign sample_out       = sample_out_q;
    assign sample_out_valid = sample_out_valid_q;
    assign busy             = busy_q;
    assign overrun          = overrun_q;
`ifdef FX_WATCHDOG_EN
    assign fx_timeout       = fx_timeout_q;
`else
    assign fx_timeout       = '0;
`endif

endmodule
